// File: rtl/ramio_arbiter.sv
// ramio_arbiter
// Shares one ramio command port between two requesters (port 0 = core,
// port 1 = secondary master such as DMA or an SD-card loader).
//
// Each requester drives a one-cycle strobe that is latched into a private
// pending slot. A three-state FSM (IDLE -> ISSUE -> WAIT) picks a winner,
// issues the latched command to ramio for exactly one cycle, waits for
// ramio to drop busy, and then frees the owner.
//
// Parameters
//   RoundRobin      : 1 = alternate on contention, 0 = port 0 always wins
//   AddressBitWidth : width of every address bus
//
// Ports
//   clk, rst_n                 : clock and asynchronous active-low reset
//   mN_enable                  : request strobe from requester N
//   mN_read_type/write_type    : ramio command encoding (0 = none)
//   mN_address, mN_data_in     : request address and write data
//   mN_data_out                : read data (shared with both requesters)
//   mN_data_out_ready          : read data valid for requester N
//   mN_busy                    : requester N has a pending/in-flight request
//   ramio_enable               : one-cycle issue strobe to ramio
//   ramio_read_type/write_type : issued command encoding
//   ramio_address, ramio_data_in : issued address and write data
//   ramio_data_out, ramio_data_out_ready : read data return from ramio
//   ramio_busy                 : ramio is executing a command
module ramio_arbiter #(
   parameter int RoundRobin      = 1,
   parameter int AddressBitWidth = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,

   input  logic                       m0_enable,
   input  logic [2:0]                 m0_read_type,
   input  logic [1:0]                 m0_write_type,
   input  logic [AddressBitWidth-1:0] m0_address,
   input  logic [31:0]                m0_data_in,
   output logic [31:0]                m0_data_out,
   output logic                       m0_data_out_ready,
   output logic                       m0_busy,

   input  logic                       m1_enable,
   input  logic [2:0]                 m1_read_type,
   input  logic [1:0]                 m1_write_type,
   input  logic [AddressBitWidth-1:0] m1_address,
   input  logic [31:0]                m1_data_in,
   output logic [31:0]                m1_data_out,
   output logic                       m1_data_out_ready,
   output logic                       m1_busy,

   output logic                       ramio_enable,
   output logic [2:0]                 ramio_read_type,
   output logic [1:0]                 ramio_write_type,
   output logic [AddressBitWidth-1:0] ramio_address,
   output logic [31:0]                ramio_data_in,
   input  logic [31:0]                ramio_data_out,
   input  logic                       ramio_data_out_ready,
   input  logic                       ramio_busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // One latched request per port.
   typedef struct packed {
      logic                       valid;
      logic [2:0]                 read_type;
      logic [1:0]                 write_type;
      logic [AddressBitWidth-1:0] address;
      logic [31:0]                data;
   } pend_t;

   localparam int PendWidth = $bits(pend_t);
   localparam bit RrEnable  = (RoundRobin != 0);

   state_t state_r;
   logic   owner_r;        // port currently holding ramio
   logic   last_grant_r;   // port served most recently
   logic   wait_first_r;   // first WAIT cycle, ramio_busy not yet trustworthy
   pend_t  pend0_r;
   pend_t  pend1_r;

   logic   cap0_s;
   logic   cap1_s;
   logic   winner_s;
   pend_t  win_cmd_s;

   // Build a valid pending entry from a requester's command fields.
   function automatic pend_t make_pend(
      input logic [2:0]                 rt,
      input logic [1:0]                 wt,
      input logic [AddressBitWidth-1:0] addr,
      input logic [31:0]                data
   );
      pend_t p;
      p.valid      = 1'b1;
      p.read_type  = rt;
      p.write_type = wt;
      p.address    = addr;
      p.data       = data;
      return p;
   endfunction

   // Strobes are only accepted while the port is idle; a strobe during busy is dropped.
   always_comb begin
      cap0_s = m0_enable & ~m0_busy;
      cap1_s = m1_enable & ~m1_busy;
   end

   // Winner selection among valid pending entries.
   always_comb begin
      winner_s = 1'b0;
      if (pend0_r.valid && pend1_r.valid) begin
         if (RrEnable) begin
            // On contention the port that was not served last goes next.
            winner_s = ~last_grant_r;
         end else begin
            winner_s = 1'b0;
         end
      end else if (pend1_r.valid) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
      // win_cmd_s.valid doubles as "any request pending".
      win_cmd_s = winner_s ? pend1_r : pend0_r;
   end

   // Read data is broadcast; ready is steered to the current owner only.
   always_comb begin
      m0_data_out       = ramio_data_out;
      m1_data_out       = ramio_data_out;
      m0_data_out_ready = ramio_data_out_ready & ~owner_r & (state_r != ST_IDLE);
      m1_data_out_ready = ramio_data_out_ready &  owner_r & (state_r != ST_IDLE);
   end

   // Request capture, arbitration FSM and registered command/busy outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r          <= ST_IDLE;
         owner_r          <= 1'b0;
         last_grant_r     <= 1'b1;   // makes port 0 win the first tie
         wait_first_r     <= 1'b0;
         pend0_r          <= {PendWidth{1'b0}};
         pend1_r          <= {PendWidth{1'b0}};
         m0_busy          <= 1'b0;
         m1_busy          <= 1'b0;
         ramio_enable     <= 1'b0;
         ramio_read_type  <= 3'b000;
         ramio_write_type <= 2'b00;
         ramio_address    <= {AddressBitWidth{1'b0}};
         ramio_data_in    <= 32'h0000_0000;
      end else begin
         // A capturing port is never the owner, so these never collide with
         // the owner's valid-clear or busy-clear below.
         if (cap0_s) begin
            pend0_r <= make_pend(m0_read_type, m0_write_type, m0_address, m0_data_in);
            m0_busy <= 1'b1;
         end else begin
            pend0_r <= pend0_r;
         end
         if (cap1_s) begin
            pend1_r <= make_pend(m1_read_type, m1_write_type, m1_address, m1_data_in);
            m1_busy <= 1'b1;
         end else begin
            pend1_r <= pend1_r;
         end

         case (state_r)
            ST_IDLE: begin
               if (win_cmd_s.valid && !ramio_busy) begin
                  owner_r          <= winner_s;
                  ramio_enable     <= 1'b1;
                  ramio_read_type  <= win_cmd_s.read_type;
                  ramio_write_type <= win_cmd_s.write_type;
                  ramio_address    <= win_cmd_s.address;
                  ramio_data_in    <= win_cmd_s.data;
                  state_r          <= ST_ISSUE;
               end else begin
                  ramio_enable     <= 1'b0;
               end
            end

            ST_ISSUE: begin
               // Command fields stay put; only the strobe drops.
               ramio_enable <= 1'b0;
               wait_first_r <= 1'b1;
               state_r      <= ST_WAIT;
               if (owner_r) begin
                  pend1_r.valid <= 1'b0;
               end else begin
                  pend0_r.valid <= 1'b0;
               end
            end

            ST_WAIT: begin
               // ramio raises busy one cycle after the strobe, so the first
               // WAIT cycle ignores it.
               if (wait_first_r) begin
                  wait_first_r <= 1'b0;
               end else if (!ramio_busy) begin
                  last_grant_r <= owner_r;
                  state_r      <= ST_IDLE;
                  if (owner_r) begin
                     m1_busy <= 1'b0;
                  end else begin
                     m0_busy <= 1'b0;
                  end
               end else begin
                  state_r <= ST_WAIT;
               end
            end

            default: begin
               ramio_enable <= 1'b0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ramio_arbiter.sv
// Bench for ramio_arbiter. Two instances: index 0 is round-robin, index 1
// fixed priority. Each has its own small ramio model (4-cycle busy, read
// data from a memory map, ~address for unwritten locations). Expected
// issued commands and read data are queued as stimulus is driven and
// compared by a monitor as the DUT produces them.
module tb_ramio_arbiter;

   localparam int LAT = 4;

   logic clk;
   logic rst_n;

   logic        en   [2][2];
   logic [2:0]  rt   [2][2];
   logic [1:0]  wt   [2][2];
   logic [31:0] addr [2][2];
   logic [31:0] din  [2][2];
   logic [31:0] dout [2][2];
   logic        drdy [2][2];
   logic        busy [2][2];

   logic        r_en   [2];
   logic [2:0]  r_rt   [2];
   logic [1:0]  r_wt   [2];
   logic [31:0] r_addr [2];
   logic [31:0] r_din  [2];
   logic [31:0] r_dout [2];
   logic        r_rdy  [2];
   logic        r_busy [2];

   int          cnt      [2];
   logic        cur_read [2];
   logic [31:0] cur_addr [2];
   logic [31:0] mem [logic [32:0]];

   logic [68:0] cq0[$], cq1[$];
   logic [31:0] rq00[$], rq01[$], rq10[$], rq11[$];

   int n_assert = 0;
   int n_fail   = 0;

   ramio_arbiter #(.RoundRobin(1), .AddressBitWidth(32)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .m0_enable(en[0][0]), .m0_read_type(rt[0][0]), .m0_write_type(wt[0][0]),
      .m0_address(addr[0][0]), .m0_data_in(din[0][0]), .m0_data_out(dout[0][0]),
      .m0_data_out_ready(drdy[0][0]), .m0_busy(busy[0][0]),
      .m1_enable(en[0][1]), .m1_read_type(rt[0][1]), .m1_write_type(wt[0][1]),
      .m1_address(addr[0][1]), .m1_data_in(din[0][1]), .m1_data_out(dout[0][1]),
      .m1_data_out_ready(drdy[0][1]), .m1_busy(busy[0][1]),
      .ramio_enable(r_en[0]), .ramio_read_type(r_rt[0]), .ramio_write_type(r_wt[0]),
      .ramio_address(r_addr[0]), .ramio_data_in(r_din[0]), .ramio_data_out(r_dout[0]),
      .ramio_data_out_ready(r_rdy[0]), .ramio_busy(r_busy[0])
   );

   ramio_arbiter #(.RoundRobin(0), .AddressBitWidth(32)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_enable(en[1][0]), .m0_read_type(rt[1][0]), .m0_write_type(wt[1][0]),
      .m0_address(addr[1][0]), .m0_data_in(din[1][0]), .m0_data_out(dout[1][0]),
      .m0_data_out_ready(drdy[1][0]), .m0_busy(busy[1][0]),
      .m1_enable(en[1][1]), .m1_read_type(rt[1][1]), .m1_write_type(wt[1][1]),
      .m1_address(addr[1][1]), .m1_data_in(din[1][1]), .m1_data_out(dout[1][1]),
      .m1_data_out_ready(drdy[1][1]), .m1_busy(busy[1][1]),
      .ramio_enable(r_en[1]), .ramio_read_type(r_rt[1]), .ramio_write_type(r_wt[1]),
      .ramio_address(r_addr[1]), .ramio_data_in(r_din[1]), .ramio_data_out(r_dout[1]),
      .ramio_data_out_ready(r_rdy[1]), .ramio_busy(r_busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read value of the memory model.
   function automatic logic [31:0] rd_val(input logic d, input logic [31:0] a);
      if (mem.exists({d, a})) return mem[{d, a}];
      return ~a;
   endfunction

   // ramio model: busy for LAT cycles after a strobe, read data with the last busy cycle's end.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            cnt[d]      <= 0;
            r_rdy[d]    <= 1'b0;
            r_dout[d]   <= 32'h0;
            cur_read[d] <= 1'b0;
            cur_addr[d] <= 32'h0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            r_rdy[d] <= 1'b0;
            if (r_en[d]) begin
               cnt[d]      <= LAT;
               cur_read[d] <= (r_rt[d] != 3'd0);
               cur_addr[d] <= r_addr[d];
               if (r_wt[d] != 2'd0) mem[{1'(d), r_addr[d]}] = r_din[d];
            end else if (cnt[d] != 0) begin
               cnt[d] <= cnt[d] - 1;
               if (cnt[d] == 1 && cur_read[d]) begin
                  r_rdy[d]  <= 1'b1;
                  r_dout[d] <= rd_val(1'(d), cur_addr[d]);
               end
            end
         end
      end
   end

   always_comb begin
      for (int d = 0; d < 2; d++) r_busy[d] = (cnt[d] != 0);
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic exp_cmd(input int d, input logic [2:0] t_rt, input logic [1:0] t_wt,
                          input logic [31:0] a, input logic [31:0] dd);
      if (d == 0) cq0.push_back({t_rt, t_wt, a, dd});
      else        cq1.push_back({t_rt, t_wt, a, dd});
   endtask

   task automatic exp_rd(input int d, input int p, input logic [31:0] v);
      if (d == 0 && p == 0)      rq00.push_back(v);
      else if (d == 0)           rq01.push_back(v);
      else if (p == 0)           rq10.push_back(v);
      else                       rq11.push_back(v);
   endtask

   task automatic pop_cmd(input int d, output logic ok, output logic [68:0] v);
      ok = 1'b0; v = 69'd0;
      if (d == 0 && cq0.size() != 0) begin ok = 1'b1; v = cq0.pop_front(); end
      if (d == 1 && cq1.size() != 0) begin ok = 1'b1; v = cq1.pop_front(); end
   endtask

   task automatic pop_rd(input int d, input int p, output logic ok, output logic [31:0] v);
      ok = 1'b0; v = 32'd0;
      if (d == 0 && p == 0 && rq00.size() != 0) begin ok = 1'b1; v = rq00.pop_front(); end
      if (d == 0 && p == 1 && rq01.size() != 0) begin ok = 1'b1; v = rq01.pop_front(); end
      if (d == 1 && p == 0 && rq10.size() != 0) begin ok = 1'b1; v = rq10.pop_front(); end
      if (d == 1 && p == 1 && rq11.size() != 0) begin ok = 1'b1; v = rq11.pop_front(); end
   endtask

   function automatic int cmd_left(input int d);
      return (d == 0) ? cq0.size() : cq1.size();
   endfunction

   function automatic int rd_left(input int d);
      return (d == 0) ? (rq00.size() + rq01.size()) : (rq10.size() + rq11.size());
   endfunction

   task automatic set_req(input int d, input int p, input logic [2:0] t_rt, input logic [1:0] t_wt,
                          input logic [31:0] a, input logic [31:0] dd);
      en[d][p] = 1'b1; rt[d][p] = t_rt; wt[d][p] = t_wt; addr[d][p] = a; din[d][p] = dd;
   endtask

   // Advance one cycle; strobes last exactly one cycle.
   task automatic tick();
      @(negedge clk);
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) en[d][p] = 1'b0;
   endtask

   task automatic wait_idle(input int d, input string tag);
      int n;
      n = 0;
      while ((busy[d][0] || busy[d][1] || r_busy[d] || cmd_left(d) != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 128'(n < 300), 128'(1));
      check({tag, "_rd_left"}, 128'(rd_left(d)), 128'(0));
      repeat (2) @(negedge clk);
   endtask

   // Monitor: issued commands, strobe width/spacing, and read returns.
   initial begin
      logic        prev_en [2];
      logic        armed   [2];
      int          gap     [2];
      logic        ok;
      logic [68:0] cv;
      logic [31:0] rv;
      for (int d = 0; d < 2; d++) begin prev_en[d] = 1'b0; armed[d] = 1'b0; gap[d] = 0; end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
               prev_en[d] = 1'b0; armed[d] = 1'b0; gap[d] = 0;
            end else begin
               gap[d]++;
               if (r_en[d]) begin
                  check("enable_width", 128'(prev_en[d]), 128'(0));
                  if (armed[d]) check("enable_gap_ge3", 128'(gap[d] >= 3), 128'(1));
                  armed[d] = 1'b1;
                  gap[d]   = 0;
                  pop_cmd(d, ok, cv);
                  if (!ok) check("unexpected_enable", 128'(r_en[d]), 128'(0));
                  else check($sformatf("cmd_d%0d", d), 128'({r_rt[d], r_wt[d], r_addr[d], r_din[d]}), 128'(cv));
               end
               prev_en[d] = r_en[d];
               for (int p = 0; p < 2; p++) begin
                  if (drdy[d][p]) begin
                     pop_rd(d, p, ok, rv);
                     if (!ok) check($sformatf("unexpected_ready_d%0d_p%0d", d, p), 128'(drdy[d][p]), 128'(0));
                     else check($sformatf("rdata_d%0d_p%0d", d, p), 128'(dout[d][p]), 128'(rv));
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) begin
            en[d][p] = 1'b0; rt[d][p] = 3'd0; wt[d][p] = 2'd0; addr[d][p] = 32'd0; din[d][p] = 32'd0;
         end
      mem[{1'b0, 32'h0000_1000}] = 32'hDEAD_BEEF;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_enable", 128'(r_en[0]), 128'(0));
      check("rst_cmd", 128'({r_rt[0], r_wt[0], r_addr[0], r_din[0]}), 128'(0));
      check("rst_busy", 128'({busy[0][0], busy[0][1], busy[1][0], busy[1][1]}), 128'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single read with issue-latency checks
      set_req(0, 0, 3'b111, 2'b00, 32'h0000_1000, 32'd0);
      exp_cmd(0, 3'b111, 2'b00, 32'h0000_1000, 32'd0);
      exp_rd(0, 0, 32'hDEAD_BEEF);
      tick();
      check("single_busy_after_k", 128'({busy[0][0], busy[0][1]}), 128'(2'b10));
      check("single_no_enable_yet", 128'(r_en[0]), 128'(0));
      tick();
      check("single_enable_k2", 128'(r_en[0]), 128'(1));
      wait_idle(0, "single");

      // last_grant is now 0: a tie on the round-robin instance goes to port 1
      set_req(0, 0, 3'b111, 2'b00, 32'h0000_5000, 32'd0);
      set_req(0, 1, 3'b001, 2'b00, 32'h0000_6000, 32'd0);
      exp_cmd(0, 3'b001, 2'b00, 32'h0000_6000, 32'd0);
      exp_cmd(0, 3'b111, 2'b00, 32'h0000_5000, 32'd0);
      exp_rd(0, 1, ~32'h0000_6000);
      exp_rd(0, 0, ~32'h0000_5000);
      tick();
      wait_idle(0, "rr_alt");

      // Asynchronous reset in the middle of WAIT
      set_req(0, 0, 3'b111, 2'b00, 32'h0000_4000, 32'd0);
      exp_cmd(0, 3'b111, 2'b00, 32'h0000_4000, 32'd0);
      tick();
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_enable", 128'(r_en[0]), 128'(0));
      check("midrst_cmd", 128'({r_rt[0], r_wt[0], r_addr[0], r_din[0]}), 128'(0));
      check("midrst_busy", 128'({busy[0][0], busy[0][1]}), 128'(0));
      check("midrst_ready", 128'({drdy[0][0], drdy[0][1]}), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Round-robin contention after reset: 0,1 per round
      for (int i = 0; i < 4; i++) begin
         set_req(0, 0, 3'b111, 2'b00, 32'h0000_0100 + 32'(i * 16), 32'd0);
         set_req(0, 1, 3'b001, 2'b00, 32'h0000_0200 + 32'(i * 16), 32'd0);
         exp_cmd(0, 3'b111, 2'b00, 32'h0000_0100 + 32'(i * 16), 32'd0);
         exp_cmd(0, 3'b001, 2'b00, 32'h0000_0200 + 32'(i * 16), 32'd0);
         exp_rd(0, 0, ~(32'h0000_0100 + 32'(i * 16)));
         exp_rd(0, 1, ~(32'h0000_0200 + 32'(i * 16)));
         tick();
         wait_idle(0, "rr_contention");
      end

      // Write from port 1, then read-back from port 0 one cycle later
      set_req(0, 1, 3'b000, 2'b11, 32'hFFFF_FFF8, 32'h1234_5678);
      exp_cmd(0, 3'b000, 2'b11, 32'hFFFF_FFF8, 32'h1234_5678);
      tick();
      set_req(0, 0, 3'b111, 2'b00, 32'hFFFF_FFF8, 32'd0);
      exp_cmd(0, 3'b111, 2'b00, 32'hFFFF_FFF8, 32'd0);
      exp_rd(0, 0, 32'h1234_5678);
      tick();
      wait_idle(0, "write_read");

      // Protocol violation: strobes while busy are ignored
      set_req(0, 0, 3'b111, 2'b00, 32'h0000_2000, 32'd0);
      exp_cmd(0, 3'b111, 2'b00, 32'h0000_2000, 32'd0);
      exp_rd(0, 0, ~32'h0000_2000);
      tick();
      set_req(0, 0, 3'b000, 2'b11, 32'h0000_3000, 32'hAAAA_5555);
      tick();
      repeat (2) @(negedge clk);
      set_req(0, 0, 3'b111, 2'b00, 32'h0000_3004, 32'd0);
      tick();
      wait_idle(0, "violation");
      repeat (8) @(negedge clk);
      check("violation_no_extra", 128'(cmd_left(0)), 128'(0));

      // Fixed priority: solo port-0 request, then a tie still goes to port 0
      set_req(1, 0, 3'b111, 2'b00, 32'h0000_0010, 32'd0);
      exp_cmd(1, 3'b111, 2'b00, 32'h0000_0010, 32'd0);
      exp_rd(1, 0, ~32'h0000_0010);
      tick();
      wait_idle(1, "fp_solo");
      set_req(1, 0, 3'b111, 2'b00, 32'h0000_0020, 32'd0);
      set_req(1, 1, 3'b111, 2'b00, 32'h0000_0030, 32'd0);
      exp_cmd(1, 3'b111, 2'b00, 32'h0000_0020, 32'd0);
      exp_cmd(1, 3'b111, 2'b00, 32'h0000_0030, 32'd0);
      exp_rd(1, 0, ~32'h0000_0020);
      exp_rd(1, 1, ~32'h0000_0030);
      tick();
      wait_idle(1, "fp_tie");

      // Fixed priority: port 0 re-requests right after completing
      set_req(1, 0, 3'b111, 2'b00, 32'h0000_0040, 32'd0);
      set_req(1, 1, 3'b111, 2'b00, 32'h0000_0050, 32'd0);
      exp_cmd(1, 3'b111, 2'b00, 32'h0000_0040, 32'd0);
      exp_cmd(1, 3'b111, 2'b00, 32'h0000_0050, 32'd0);
      exp_cmd(1, 3'b111, 2'b00, 32'h0000_0060, 32'd0);
      exp_rd(1, 0, ~32'h0000_0040);
      exp_rd(1, 1, ~32'h0000_0050);
      exp_rd(1, 0, ~32'h0000_0060);
      tick();
      n = 0;
      while (busy[1][0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("fp_reissue_timeout", 128'(n < 100), 128'(1));
      set_req(1, 0, 3'b111, 2'b00, 32'h0000_0060, 32'd0);
      tick();
      check("fp_reissue_latched", 128'(busy[1][0]), 128'(1));
      wait_idle(1, "fp_reissue");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ramio_arbiter.md
# ramio_arbiter

Two-port arbiter that shares the single `ramio` memory/IO interface between two requesters. Port 0 is the `core`; port 1 is a secondary master such as a DMA or SD-card loader. Each port sees a private copy of the `ramio` interface. The arbiter latches one-cycle requests, grants the shared port round-robin (or with fixed priority), issues the command, and routes completion and read data back to the owner. It sits between the requesters and `ramio`, in the `clk` (SDRAM controller) clock domain.

## Interface
Parameters:
- `RoundRobin`, default 1. 1 selects alternating priority on contention; 0 gives port 0 fixed priority.
- `AddressBitWidth`, default 32. Width of all address buses.

Ports (N = 0, 1):
- `clk` in 1. Single clock, same as `ramio`.
- `rst_n` in 1. Asynchronous, active-low reset.
- `mN_enable` in 1. One-cycle request strobe from requester N.
- `mN_read_type` in 3. `ramio` read encoding; 0 means not a read.
- `mN_write_type` in 2. `ramio` write encoding; 0 means not a write.
- `mN_address` in `AddressBitWidth`. Request address.
- `mN_data_in` in 32. Write data.
- `mN_data_out` out 32. Read data.
- `mN_data_out_ready` out 1. Read data valid for requester N.
- `mN_busy` out 1. Requester N has a pending or in-flight transaction.
- `ramio_enable` out 1. Issue strobe to `ramio`.
- `ramio_read_type` out 3. Issued read type.
- `ramio_write_type` out 2. Issued write type.
- `ramio_address` out `AddressBitWidth`. Issued address.
- `ramio_data_in` out 32. Issued write data.
- `ramio_data_out` in 32. Read data from `ramio`.
- `ramio_data_out_ready` in 1. Read data valid from `ramio`.
- `ramio_busy` in 1. `ramio` is busy.

## Operation
- **Request capture.** On a rising `clk` with `mN_enable`=1 and `mN_busy`=0, port N's command is stored in `pend_N`, a per-port register holding types, address and data, and its valid bit is set.
  - A strobe while `mN_busy`=1 is a protocol violation. It is ignored and not latched.
- **State machine.** States are IDLE, ISSUE, WAIT.
  - IDLE: if any `pend_N` is valid and `ramio_busy`=0, select the winner, set `owner` and go to ISSUE.
  - ISSUE: drive `ramio_enable`=1 with the owner's latched command for exactly one cycle, clear the owner's pending-valid bit, then go to WAIT.
  - WAIT: the first cycle after ISSUE is always spent in WAIT, to cover `ramio_busy` rise latency. On any later cycle, `ramio_busy`=0 marks completion; set `last_grant` = `owner` and go to IDLE.
- **Arbitration.**
  - A single valid request wins.
  - On contention with `RoundRobin`=1, the port that is not `last_grant` wins.
  - On contention with `RoundRobin`=0, port 0 always wins.
- **Read return.**
  - `mN_data_out` = `ramio_data_out` for both ports; the wires are shared.
  - `mN_data_out_ready` = `ramio_data_out_ready` AND (`owner`==N) AND state≠IDLE. This is combinational.
- **`mN_busy`** is registered. It is set on the edge that captures the request and cleared on the edge leaving WAIT for that owner.
- **Command outputs** are registered and hold their last value outside ISSUE. Only `ramio_enable` qualifies them.
- **Reset (asynchronous, any state)** forces:
  - state IDLE and both pending-valid bits cleared;
  - `owner`=0 and `last_grant`=1, so port 0 wins the first tie;
  - all `ramio_*` outputs 0 and both `mN_busy` = 0.
  - An in-flight transaction is abandoned; `ramio` shares the same reset.

## Timing
- Strobe at edge k, uncontended and IDLE: `mN_busy`=1 after k. Selection happens at k+1; `ramio_enable`=1 is visible during cycle k+2.
- Minimum occupancy is ISSUE plus 2 WAIT cycles, so back-to-back grants are at least 3 cycles apart.
- A loser's request stays pending. It is issued in the IDLE following the winner's completion, with no extra gap beyond the arbitration cycle.
- Simultaneous `mN_enable` from both ports in one cycle: both are latched and served in grant order.
- A new strobe from port N is accepted no earlier than the cycle after `mN_busy` falls.
- Completion and a new request from the other port on the same edge: the new request is latched and competes in the next IDLE.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-WAIT → all outputs 0 on the asynchronous edge. After release, the first contention grants port 0.
- **Single read.** `m0` reads address 0x0000_1000 (read_type=3'b111). `ramio` model holds busy for 4 cycles then returns 0xDEADBEEF with `ramio_data_out_ready` → `m0_data_out_ready`=1 with 0xDEADBEEF, `m1_data_out_ready` stays 0, and `m0_busy` falls after completion.
- **Contention, round-robin.** Both ports strobe in the same cycle, repeated 4 times → grant order 0,1,0,1 (after reset). `ramio_enable` pulses are exactly one cycle wide, at least 3 cycles apart.
- **Fixed priority** (`RoundRobin`=0). `m0` re-requests immediately after each completion while `m1` stays pending → `m1` is granted only when `m0` has no valid pending request at IDLE.
- **Writes.** `m1` writes 0x1234_5678 to address 0xFFFF_FFF8 (write_type=2'b11), then `m0` reads the same address → `ramio` sees the write first with the exact fields, then the read.
- **Protocol violation.** `m0_enable` pulsed while `m0_busy`=1 → no extra `ramio_enable`, and the in-flight transaction completes unchanged.
